// File: rtl/caesar_rr_if.sv
// caesar_rr_if
// Bundles the per-channel request side and the tagged plaintext output of
// the Caesar round-robin scheduler.
//   valid_i  [N_CH]            per-channel ciphertext valid
//   data_i   [N_CH*D_WIDTH]    per-channel ciphertext, channel k at [k*D_WIDTH +: D_WIDTH]
//   key_i    [N_CH*KEY_WIDTH]  per-channel key, channel k at [k*KEY_WIDTH +: KEY_WIDTH]
//   ready_o  [N_CH]            registered one-hot grant
//   busy                       scheduler not idle
//   data_o   [D_WIDTH]         decrypted character
//   ch_o     [CH_W]            source channel of data_o
//   valid_o                    data_o/ch_o valid
// master: request/consumer side.  slave: the scheduler.
interface caesar_rr_if #(
  parameter int N_CH      = 4,
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 16,
  parameter int CH_W      = 2
);
  logic [N_CH-1:0]           valid_i;
  logic [N_CH*D_WIDTH-1:0]   data_i;
  logic [N_CH*KEY_WIDTH-1:0] key_i;
  logic [N_CH-1:0]           ready_o;
  logic                      busy;
  logic [D_WIDTH-1:0]        data_o;
  logic [CH_W-1:0]           ch_o;
  logic                      valid_o;

  modport master (
    output valid_i, data_i, key_i,
    input  ready_o, busy, data_o, ch_o, valid_o
  );

  modport slave (
    input  valid_i, data_i, key_i,
    output ready_o, busy, data_o, ch_o, valid_o
  );
endinterface

// File: rtl/caesar_rr_scheduler.sv
// caesar_rr_scheduler
// Shares one Caesar subtract datapath between N_CH character streams using
// round-robin arbitration with bursts of at most BURST_LEN beats. Each
// decrypted character leaves one cycle after its transfer, tagged with the
// source channel.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    caesar_rr_if.slave (valid_i/data_i/key_i in, ready_o/busy/data_o/ch_o/valid_o out)
// Optional macro CAESAR_KEY_LOCK_EN: when defined, the granted channel's key
// is captured at grant time and used for the whole burst; otherwise the live
// key is used on every beat.
//
// state | meaning
// IDLE  | no request pending, outputs quiet
// ARB   | one bubble cycle: pick next requester after last grant
// BURST | granted channel owns the datapath until BURST_LEN beats or valid drops
module caesar_rr_scheduler #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 16,
  parameter int N_CH      = 4,
  parameter int CH_W      = 2,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  caesar_rr_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_last;
  logic [CH_W-1:0]     r_g;
  logic [7:0]          r_cnt;
  logic [N_CH-1:0]     r_ready;
  logic [D_WIDTH-1:0]  r_data;
  logic [CH_W-1:0]     r_ch;
  logic                r_valid;
`ifdef CAESAR_KEY_LOCK_EN
  logic [KEY_WIDTH-1:0] r_key;
`endif

  logic [D_WIDTH-1:0]   w_data_arr [N_CH];
  logic [KEY_WIDTH-1:0] w_key_arr  [N_CH];
  logic [KEY_WIDTH-1:0] w_key_use;
  logic [D_WIDTH-1:0]   w_plain;
  logic                 w_any;
  logic                 w_xfer;
  logic [7:0]           w_cnt_nxt;
  logic                 w_last_beat;
  logic                 w_arb_found;
  logic [CH_W-1:0]      w_arb_idx;
  logic [CH_W-1:0]      w_cand;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_data_arr[k] = bus.data_i[k*D_WIDTH +: D_WIDTH];
    assign w_key_arr[k]  = bus.key_i[k*KEY_WIDTH +: KEY_WIDTH];
  end

`ifdef CAESAR_KEY_LOCK_EN
  assign w_key_use = r_key;
`else
  assign w_key_use = w_key_arr[r_g];
`endif

  // Subtract at key width, then keep the low character bits (mod 2^D_WIDTH).
  assign w_plain     = D_WIDTH'(KEY_WIDTH'(w_data_arr[r_g]) - w_key_use);
  assign w_any       = |bus.valid_i;
  assign w_xfer      = (r_state == BURST) && bus.valid_i[r_g] && r_ready[r_g];
  assign w_cnt_nxt   = r_cnt + 8'd1;
  assign w_last_beat = w_xfer && (w_cnt_nxt == 8'(BURST_LEN));

  // Descending scan overwrites, so the nearest requester after r_last wins.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int i = N_CH; i >= 1; i--) begin
      w_cand = CH_W'((int'(r_last) + i) % N_CH);
      if (bus.valid_i[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= CH_W'(N_CH - 1);
      r_g     <= '0;
      r_cnt   <= '0;
      r_ready <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
`ifdef CAESAR_KEY_LOCK_EN
      r_key   <= '0;
`endif
    end else begin
      r_valid <= w_xfer;
      r_data  <= w_xfer ? w_plain : '0;
      r_ch    <= w_xfer ? r_g : '0;
      case (r_state)
        IDLE: begin
          if (w_any) r_state <= ARB;
        end
        ARB: begin
          if (w_arb_found) begin
            r_g     <= w_arb_idx;
            r_ready <= N_CH'(1) << w_arb_idx;
            r_cnt   <= '0;
            r_state <= BURST;
`ifdef CAESAR_KEY_LOCK_EN
            r_key   <= w_key_arr[w_arb_idx];
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        BURST: begin
          if (w_xfer) r_cnt <= w_cnt_nxt;
          if (w_last_beat || !bus.valid_i[r_g]) begin
            r_ready <= '0;
            r_last  <= r_g;
            r_state <= w_any ? ARB : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.busy    = (r_state != IDLE);
  assign bus.data_o  = r_data;
  assign bus.ch_o    = r_ch;
  assign bus.valid_o = r_valid;

endmodule
